sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port arbiter sharing the single-ported, byte-enabled on-chip SRAM between the instruction-fetch unit and the load/store unit. It sits between the CPU core and the `sram` instance. It accepts one request per cycle via a req/gnt handshake, drives the SRAM command pins from registers, and routes the one-cycle-latency read data back to the requester that issued the read. Sustained throughput is one access per cycle.

## Interface
- FIXED_PRIO, 0: 0 = round-robin between ports on conflict; 1 = data port always wins.
- Address width is the global macro `RAM_ADDR_BITS` (word address), not a parameter.

- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  `RAM_ADDR_BITS  fetch word address
- i_gnt  out  1  fetch request accepted this cycle (combinational)
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  32  fetch read data
- d_req  in  1  data request; held with all d_* inputs stable until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  `RAM_ADDR_BITS  data word address
- d_byteen  in  4  byte lanes, bit n = bits 8n+7:8n
- d_wdata  in  32  write data, lane-aligned
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  data read data valid (reads only)
- d_rdata  out  32  data read data; disabled lanes read 0
- ram_addr  out  `RAM_ADDR_BITS  to sram addr
- ram_byteen  out  4  to sram byteen
- ram_data  out  32  to sram data
- ram_rden  out  1  to sram rden
- ram_wren  out  1  to sram wren
- ram_q  in  32  from sram q

## Operation
- Grant, cycle T:
  - If only one req is high, that port is granted.
  - If both are high, FIXED_PRIO=1 grants d.
  - If both are high and FIXED_PRIO=0, the port not granted last time wins. `last` updates only on a conflict grant. After reset it is "i", so d wins the first conflict.
  - At most one gnt per cycle. A gnt is never issued without the matching req.
- Command register, cycle T+1:
  - ram_addr, ram_byteen, ram_data, ram_rden and ram_wren reflect the request granted at T.
  - Fetch: byteen = 4'hF, rden = 1, wren = 0, data = 0.
  - Data read: byteen = d_byteen, rden = 1, wren = 0.
  - Data write: byteen = d_byteen, wren = 1, rden = 0, data = d_wdata.
  - With no grant, rden = wren = 0. Addr, byteen and data hold their previous values.
- Response, cycle T+2:
  - A 1-bit owner tag plus a valid bit move with the command through a 2-stage pipeline.
  - A read issued at T+1 produces ram_q at T+2.
  - The owner's rvalid is asserted for exactly one cycle, with rdata = ram_q.
  - Writes produce no response.
  - i_rdata and d_rdata both wire to ram_q. Only rvalid is steered.
- Ordering: accesses complete in grant order. A read granted the cycle after a write to the same address returns the new data, because the write commits at the T+1 edge before the read samples at T+2.

## Timing
- Read latency: gnt at T, rvalid at T+2, fixed. No backpressure on responses: requesters must accept rvalid.
- Back-to-back grants every cycle are allowed. Interleaved i/d responses stay in their grant cycle order.
- Reset values, all asynchronous:
  - i_gnt = d_gnt = 0 (masked while rst_n = 0)
  - i_rvalid = d_rvalid = 0
  - ram_rden = ram_wren = 0
  - ram_addr = 0, ram_byteen = 0, ram_data = 0
  - owner pipeline invalid, `last` = i
- Reset mid-operation: in-flight commands are dropped. No rvalid appears after rst_n deasserts unless a new gnt was issued. An SRAM write already clocked before reset completes.
- A req dropped before gnt is a protocol violation. It is not detected and its behaviour is undefined.

## Structure
- Add to const.v:
  - `RAM_OWN_I` = 1'b0 and `RAM_OWN_D` = 1'b1 owner encodings
  - `RAM_RD_LATENCY` = 2 (gnt-to-rvalid cycles)
- One natural sub-module: sram_rr_arb.
  - Two-way round-robin or fixed-priority grant logic plus the `last` register.
  - Inputs: clk, rst_n, the two reqs, FIXED_PRIO.
  - Outputs: the two gnts.
- The `sram` instance lives in the parent, not inside this block.

## Test plan
- Single fetch: i_req = 1, i_addr = 5, word 5 preloaded to 32'hDEADBEEF.
  - i_gnt at T; ram_rden = 1 and ram_byteen = 4'hF at T+1.
  - i_rvalid = 1 and i_rdata = 32'hDEADBEEF at T+2.
  - d_rvalid stays 0.
- Conflict, round-robin: both req held for 4 cycles, FIXED_PRIO = 0.
  - Grant sequence d, i, d, i.
  - rvalid sequence at T+2 is d, i, d, i with matching data.
  - With FIXED_PRIO = 1: d every cycle, i starves until d_req drops.
- Write then read, same address, back-to-back:
  - d write addr 3, byteen 4'b0011, wdata 32'h1234ABCD over old value 32'hFFFFFFFF.
  - Next cycle d read addr 3, byteen 4'hF: returns 32'hFFFFABCD.
- Partial read: d read with byteen 4'b1000 of word 32'hAABBCCDD returns 32'hAA000000.
- Reset mid-operation: assert rst_n = 0 one cycle after a d read gnt.
  - All outputs go 0 immediately.
  - No d_rvalid after release.
  - The first conflict after release grants d.
- Idle: no req for 10 cycles.
  - ram_rden = ram_wren = 0 throughout.
  - No gnt and no rvalid.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared owner encodings, latency constant and response tag type for the SRAM arbiter.
`ifndef RAM_ADDR_BITS
`define RAM_ADDR_BITS 10
`endif
`ifndef RAM_OWN_I
`define RAM_OWN_I 1'b0
`endif
`ifndef RAM_OWN_D
`define RAM_OWN_D 1'b1
`endif
`ifndef RAM_RD_LATENCY
`define RAM_RD_LATENCY 2
`endif

package sram_arbiter_pkg;

  typedef enum logic {
    OWN_I = `RAM_OWN_I,
    OWN_D = `RAM_OWN_D
  } owner_e;

  localparam int RD_LATENCY = `RAM_RD_LATENCY;

  // Travels alongside each SRAM command; valid only for reads, which need a response.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way grant logic for the fetch and data ports: round-robin or data-first on conflict.
module sram_rr_arb
  import sram_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic d_req,
  output logic i_gnt,
  output logic d_gnt
);

  owner_e last_owner;
  logic   conflict;

  // Grants are masked while reset is held so nothing can be accepted into a flushing pipeline.
  always_comb begin
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    conflict = i_req & d_req;
    if (rst_n) begin
      if (conflict) begin
        if (FIXED_PRIO || last_owner == OWN_I) d_gnt = 1'b1;
        else                                   i_gnt = 1'b1;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  // Only contested cycles move the fairness pointer; uncontested grants leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_I;
    end else if (conflict) begin
      last_owner <= d_gnt ? OWN_D : OWN_I;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one byte-enabled single-port SRAM between instruction fetch and load/store.
// Commands are registered one cycle after grant; read data returns two cycles after grant.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_req,
  input  logic [`RAM_ADDR_BITS-1:0] i_addr,
  output logic                      i_gnt,
  output logic                      i_rvalid,
  output logic [31:0]               i_rdata,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [`RAM_ADDR_BITS-1:0] d_addr,
  input  logic [3:0]                d_byteen,
  input  logic [31:0]               d_wdata,
  output logic                      d_gnt,
  output logic                      d_rvalid,
  output logic [31:0]               d_rdata,
  output logic [`RAM_ADDR_BITS-1:0] ram_addr,
  output logic [3:0]                ram_byteen,
  output logic [31:0]               ram_data,
  output logic                      ram_rden,
  output logic                      ram_wren,
  input  logic [31:0]               ram_q
);

  tag_t tag_cmd;
  tag_t tag_rsp;

  sram_rr_arb #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (i_req),
    .d_req (d_req),
    .i_gnt (i_gnt),
    .d_gnt (d_gnt)
  );

  // Handshake: a request is accepted in the cycle its req and gnt are both high; the
  // requester holds req and its payload stable until then. Responses have no backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr   <= '0;
      ram_byteen <= '0;
      ram_data   <= '0;
      ram_rden   <= 1'b0;
      ram_wren   <= 1'b0;
      tag_cmd    <= '0;
      tag_rsp    <= '0;
    end else begin
      ram_rden <= 1'b0;
      ram_wren <= 1'b0;
      tag_cmd  <= '{valid: 1'b0, owner: OWN_I};
      if (d_gnt) begin
        ram_addr   <= d_addr;
        ram_byteen <= d_byteen;
        ram_data   <= d_wdata;
        ram_rden   <= ~d_we;
        ram_wren   <= d_we;
        tag_cmd    <= '{valid: ~d_we, owner: OWN_D};
      end else if (i_gnt) begin
        ram_addr   <= i_addr;
        ram_byteen <= 4'hF;
        ram_data   <= '0;
        ram_rden   <= 1'b1;
        tag_cmd    <= '{valid: 1'b1, owner: OWN_I};
      end
      // Second stage lines up with the SRAM's registered q output.
      tag_rsp <= tag_cmd;
    end
  end

  assign i_rvalid = tag_rsp.valid && (tag_rsp.owner == OWN_I);
  assign d_rvalid = tag_rsp.valid && (tag_rsp.owner == OWN_D);
  assign i_rdata  = ram_q;
  assign d_rdata  = ram_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised and directed bench for sram_arbiter: a grant-order memory model predicts
// grants, SRAM commands and responses every cycle; directed cases pin literal results.
`ifndef RAM_ADDR_BITS
`define RAM_ADDR_BITS 10
`endif

module tb_sram_arbiter;

  localparam int AW = `RAM_ADDR_BITS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [3:0]    d_byteen;
  logic [31:0]   d_wdata;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0]   i_rdata, d_rdata;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_byteen;
  logic [31:0]   ram_data, ram_q;
  logic          ram_rden, ram_wren;

  // fixed-priority instance, only its grants are inspected
  logic          f_i_gnt, f_i_rvalid, f_d_gnt, f_d_rvalid;
  logic [31:0]   f_i_rdata, f_d_rdata, f_ram_data;
  logic [AW-1:0] f_ram_addr;
  logic [3:0]    f_ram_byteen;
  logic          f_ram_rden, f_ram_wren;

  sram_arbiter #(.FIXED_PRIO(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_byteen(d_byteen), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_byteen(ram_byteen), .ram_data(ram_data),
    .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  sram_arbiter #(.FIXED_PRIO(1'b1)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(f_i_gnt), .i_rvalid(f_i_rvalid), .i_rdata(f_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_byteen(d_byteen), .d_wdata(d_wdata),
    .d_gnt(f_d_gnt), .d_rvalid(f_d_rvalid), .d_rdata(f_d_rdata),
    .ram_addr(f_ram_addr), .ram_byteen(f_ram_byteen), .ram_data(f_ram_data),
    .ram_rden(f_ram_rden), .ram_wren(f_ram_wren), .ram_q(32'h0)
  );

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  // ---------------- SRAM model: 16 words, registered q, disabled lanes read 0 ----------------
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr[3:0]][8*b +: 8] <= ram_data[8*b +: 8];
    if (ram_rden) ram_q <= mem[ram_addr[3:0]] & lane_mask(ram_byteen);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference view: memory contents in grant order, plus pending responses by due cycle.
  logic [31:0]   ref_mem [16] = '{default: 32'h0};
  logic [32:0]   exp_q[$];        // {owner_is_d, data}
  int            exp_due_q[$];
  bit            last_d;
  logic [AW-1:0] e_addr;
  logic [3:0]    e_be;
  logic [31:0]   e_data;
  bit            e_rd, e_wr, e_data_chk;
  int            cyc = 0;
  bit            i_gnt_seen, d_gnt_seen;

  always @(negedge clk) begin
    logic        eg_i, eg_d;
    logic [32:0] v;
    cyc++;
    i_gnt_seen = i_gnt;
    d_gnt_seen = d_gnt;
    if (!rst_n) begin
      check("rst_gnt", {i_gnt, d_gnt}, 0);
      check("rst_rvalid", {i_rvalid, d_rvalid}, 0);
      check("rst_cmd", {ram_rden, ram_wren, ram_byteen, ram_addr, ram_data}, 0);
      last_d = 0;
      exp_q.delete();
      exp_due_q.delete();
      e_addr = '0; e_be = '0; e_data = '0; e_rd = 0; e_wr = 0; e_data_chk = 1;
    end else begin
      if (i_req && d_req) begin
        eg_d = !last_d;
        eg_i = last_d;
      end else begin
        eg_i = i_req;
        eg_d = d_req;
      end
      check("gnt", {i_gnt, d_gnt}, {eg_i, eg_d});
      check("cmd_en", {ram_rden, ram_wren}, {e_rd, e_wr});
      check("cmd_addr_be", {ram_addr, ram_byteen}, {e_addr, e_be});
      if (e_data_chk) check("cmd_data", ram_data, e_data);
      if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
        v = exp_q.pop_front();
        void'(exp_due_q.pop_front());
        check("rvalid", {i_rvalid, d_rvalid}, v[32] ? 2'b01 : 2'b10);
        check("rdata", v[32] ? d_rdata : i_rdata, v[31:0]);
      end else begin
        check("rvalid_idle", {i_rvalid, d_rvalid}, 0);
      end
      // advance the model by this cycle's grant
      e_rd = 0;
      e_wr = 0;
      if (i_req && d_req) last_d = eg_d;
      if (eg_d) begin
        e_addr = d_addr; e_be = d_byteen; e_data = d_wdata;
        e_wr = d_we; e_rd = !d_we; e_data_chk = d_we;
        if (d_we) begin
          for (int b = 0; b < 4; b++)
            if (d_byteen[b]) ref_mem[d_addr[3:0]][8*b +: 8] = d_wdata[8*b +: 8];
        end else begin
          exp_q.push_back({1'b1, ref_mem[d_addr[3:0]] & lane_mask(d_byteen)});
          exp_due_q.push_back(cyc + 2);
        end
      end else if (eg_i) begin
        e_addr = i_addr; e_be = 4'hF; e_data = '0; e_rd = 1; e_data_chk = 1;
        exp_q.push_back({1'b0, ref_mem[i_addr[3:0]]});
        exp_due_q.push_back(cyc + 2);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] gseq [8];
  logic [1:0] fseq [8];
  logic [1:0] rvseq [8];
  logic [31:0] rdseq [8];
  logic [1:0] exp_g [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
  logic [1:0] exp_f [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00};

  initial begin
    int act;
    i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_byteen = '0; d_wdata = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // preload all 16 words through the data port
    for (int k = 0; k < 16; k++) begin
      d_req = 1; d_we = 1; d_addr = AW'(k); d_byteen = 4'hF;
      d_wdata = (k == 3) ? 32'hFFFFFFFF : (k == 5) ? 32'hDEADBEEF :
                (k == 7) ? 32'hAABBCCDD : (32'hA5000000 | 32'(k));
      step();
    end
    d_req = 0; d_we = 0;

    // round-robin conflict straight from reset state, fixed-priority twin alongside
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        i_req = 1; i_addr = AW'(2);
        d_req = 1; d_we = 0; d_addr = AW'(1); d_byteen = 4'hF;
      end
      if (k == 5) d_req = 0;
      if (k == 6) i_req = 0;
      @(negedge clk);
      gseq[k] = {i_gnt, d_gnt};
      fseq[k] = {f_i_gnt, f_d_gnt};
      rvseq[k] = {i_rvalid, d_rvalid};
      rdseq[k] = d_rvalid ? d_rdata : i_rdata;
      step();
    end
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rr_gnt%0d", k), gseq[k], exp_g[k]);
      check($sformatf("fix_gnt%0d", k), fseq[k], exp_f[k]);
    end
    for (int k = 2; k < 8; k++) begin
      check($sformatf("rr_rvalid%0d", k), rvseq[k], exp_g[k-2]);
      check($sformatf("rr_rdata%0d", k), rdseq[k], (exp_g[k-2] == 2'b01) ? 32'hA5000001 : 32'hA5000002);
    end

    // single fetch of word 5
    i_req = 1; i_addr = AW'(5);
    @(negedge clk); check("fetch_gnt", {i_gnt, d_gnt}, 2'b10);
    step(); i_req = 0;
    @(negedge clk); check("fetch_cmd", {ram_rden, ram_wren, ram_byteen, ram_addr}, {1'b1, 1'b0, 4'hF, AW'(5)});
    step();
    @(negedge clk);
    check("fetch_rvalid", {i_rvalid, d_rvalid}, 2'b10);
    check("fetch_rdata", i_rdata, 32'hDEADBEEF);
    step();

    // partial write then immediate read of the same word
    d_req = 1; d_we = 1; d_addr = AW'(3); d_byteen = 4'b0011; d_wdata = 32'h1234ABCD;
    step();
    d_we = 0; d_byteen = 4'hF;
    step();
    d_req = 0;
    @(negedge clk);
    step();
    @(negedge clk);
    check("wr_rd_rvalid", {i_rvalid, d_rvalid}, 2'b01);
    check("wr_rd_rdata", d_rdata, 32'hFFFFABCD);
    step();

    // single-lane read
    d_req = 1; d_we = 0; d_addr = AW'(7); d_byteen = 4'b1000;
    step();
    d_req = 0;
    @(negedge clk);
    step();
    @(negedge clk);
    check("partial_rvalid", d_rvalid, 1'b1);
    check("partial_rdata", d_rdata, 32'hAA000000);
    step();

    // idle window
    act = 0;
    repeat (10) begin
      @(negedge clk);
      act += int'(ram_rden | ram_wren | i_gnt | d_gnt | i_rvalid | d_rvalid);
      step();
    end
    check("idle_activity", act, 0);

    // random traffic with hold-until-grant requesters
    for (int c = 0; c < 600; c++) begin
      if (!i_req || i_gnt_seen) begin
        i_req = ($urandom_range(0, 99) < 55);
        i_addr = AW'($urandom_range(0, 15));
      end
      if (!d_req || d_gnt_seen) begin
        d_req = ($urandom_range(0, 99) < 55);
        d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom_range(0, 15));
        d_byteen = 4'($urandom_range(0, 15));
        d_wdata = $urandom();
      end
      step();
    end
    for (int k = 0; k < 40 && (i_req || d_req); k++) begin
      if (i_gnt_seen) i_req = 0;
      if (d_gnt_seen) d_req = 0;
      step();
    end
    check("drain", {i_req, d_req}, 0);
    repeat (3) step();

    // reset one cycle after a data read grant
    d_req = 1; d_we = 0; d_addr = AW'(1); d_byteen = 4'hF;
    @(negedge clk); check("rst_pre_gnt", {i_gnt, d_gnt}, 2'b01);
    step();
    d_req = 0;
    rst_n = 0;
    #1;
    check("rst_async_zero", {i_gnt, d_gnt, i_rvalid, d_rvalid, ram_rden, ram_wren, ram_byteen, ram_addr, ram_data}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    act = 0;
    repeat (5) begin
      @(negedge clk);
      act += int'(i_rvalid | d_rvalid);
      step();
    end
    check("rst_no_rvalid", act, 0);
    i_req = 1; i_addr = AW'(2);
    d_req = 1; d_we = 0; d_addr = AW'(1); d_byteen = 4'hF;
    @(negedge clk); check("rst_first_conflict", {i_gnt, d_gnt}, 2'b01);
    step();
    d_req = 0;
    @(negedge clk);
    step();
    i_req = 0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
